// File: rtl/uart_alu_frame_controller.sv
// UART-to-ALU frame controller: gathers operand/opcode bytes, drives the ALU,
// and hands the result to the transmitter.
module uart_alu_frame_controller #(
  parameter int NB_DATA    = 8,
  parameter int NB_OPCODE  = 6,
  parameter int N_OPERANDS = 2,
  parameter int NB_TIMEOUT = 20,
  parameter int NB_STATES  = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_DATA-1:0]            i_rx_data,
  input  logic                          i_rx_valid,
  input  logic [NB_DATA-1:0]            i_alu_result,
  input  logic                          i_tx_done,
  output logic [N_OPERANDS*NB_DATA-1:0] o_operands,
  output logic [NB_OPCODE-1:0]          o_opcode,
  output logic [NB_DATA-1:0]            o_tx_data,
  output logic                          o_tx_start,
  output logic                          o_busy,
  output logic                          o_frame_error,
  output logic                          o_overrun,
  output logic [NB_STATES-1:0]          o_dbg_state
);

  localparam logic [NB_STATES-1:0] COLLECT_OPERANDS = NB_STATES'(1);
  localparam logic [NB_STATES-1:0] COLLECT_OPCODE   = NB_STATES'(2);
  localparam logic [NB_STATES-1:0] EXECUTE          = NB_STATES'(4);
  localparam logic [NB_STATES-1:0] WAIT_TX          = NB_STATES'(8);

  localparam int NB_IDX = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_OPERANDS - 1);

  logic [NB_STATES-1:0]  state;
  logic [NB_IDX-1:0]     idx;
  logic [NB_TIMEOUT-1:0] tmo;
  logic                  tmo_full;

  assign tmo_full    = &tmo;
  assign o_busy      = state[2] | state[3];
  assign o_dbg_state = state;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= COLLECT_OPERANDS;
      idx           <= '0;
      tmo           <= '0;
      o_operands    <= '0;
      o_opcode      <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_frame_error <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_tx_start    <= 1'b0;
      o_frame_error <= 1'b0;
      o_overrun     <= 1'b0;
      unique case (1'b1)
        state[0]: begin
          if (i_rx_valid) begin
            for (int i = 0; i < N_OPERANDS; i++)
              if (idx == NB_IDX'(i))
                o_operands[i*NB_DATA +: NB_DATA] <= i_rx_data;
            tmo <= '0;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= COLLECT_OPCODE;
            end else begin
              idx <= idx + NB_IDX'(1);
            end
          end else if (idx != '0) begin
            // partial frame idle: abort once the counter saturates
            if (tmo_full) begin
              o_frame_error <= 1'b1;
              idx           <= '0;
              tmo           <= '0;
            end else begin
              tmo <= tmo + NB_TIMEOUT'(1);
            end
          end
        end
        state[1]: begin
          if (i_rx_valid) begin
            o_opcode <= i_rx_data[NB_OPCODE-1:0];
            tmo      <= '0;
            state    <= EXECUTE;
          end else if (tmo_full) begin
            o_frame_error <= 1'b1;
            idx           <= '0;
            tmo           <= '0;
            state         <= COLLECT_OPERANDS;
          end else begin
            tmo <= tmo + NB_TIMEOUT'(1);
          end
        end
        state[2]: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          o_overrun  <= i_rx_valid;
          tmo        <= '0;
          state      <= WAIT_TX;
        end
        state[3]: begin
          o_overrun <= i_rx_valid;
          tmo       <= '0;
          if (i_tx_done) begin
            idx   <= '0;
            state <= COLLECT_OPERANDS;
          end
        end
        default: begin
          idx   <= '0;
          tmo   <= '0;
          state <= COLLECT_OPERANDS;
        end
      endcase
    end
  end

endmodule
